// File: rtl/ipd_pkg.sv
// Shared types and constants for the command decoder: opcodes, FSM states,
// and the bit positions inside the one-hot operation enable vector.
package ipd_pkg;

   localparam int ELEM_W = 8;
   localparam int N_EN   = 6;

   localparam int EN_READ = 0;
   localparam int EN_SUM  = 1;
   localparam int EN_AVG  = 2;
   localparam int EN_EUC  = 3;
   localparam int EN_MAN  = 4;
   localparam int EN_DOT  = 5;

   typedef enum logic [ELEM_W-1:0] {
      OP_LOAD_A = 8'h01,
      OP_LOAD_B = 8'h02,
      OP_READ_A = 8'h03,
      OP_READ_B = 8'h04,
      OP_SUM    = 8'h05,
      OP_AVG    = 8'h06,
      OP_EUC    = 8'h07,
      OP_MAN    = 8'h08,
      OP_DOT    = 8'h09
   } opcode_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_ISSUE,
      ST_BUSY
   } state_e;

   // Maps a read/compute opcode to its enable bit; anything else yields zero.
   function automatic logic [N_EN-1:0] op_enables(input logic [ELEM_W-1:0] op);
      logic [N_EN-1:0] en;
      en = '0;
      case (op)
         OP_READ_A, OP_READ_B: en[EN_READ] = 1'b1;
         OP_SUM:               en[EN_SUM]  = 1'b1;
         OP_AVG:               en[EN_AVG]  = 1'b1;
         OP_EUC:               en[EN_EUC]  = 1'b1;
         OP_MAN:               en[EN_MAN]  = 1'b1;
         OP_DOT:               en[EN_DOT]  = 1'b1;
         default:              en          = '0;
      endcase
      return en;
   endfunction

endpackage

// File: rtl/input_cmd_decoder_if.sv
// Bus between the UART RX / TX-done side and the command decoder.
// The master drives received bytes and op_done; the slave (decoder) drives the rest.
interface input_cmd_decoder_if
   import ipd_pkg::*;
   #(parameter int unsigned N_ELEMENTS = 1024);

   localparam int unsigned ADDR_W = (N_ELEMENTS > 1) ? $clog2(N_ELEMENTS) : 1;

   logic [ELEM_W-1:0] rx_data;
   logic              rx_ready;
   logic              op_done;
   logic              wr_en_a;
   logic              wr_en_b;
   logic [ADDR_W-1:0] wr_addr;
   logic [ELEM_W-1:0] wr_data;
   logic [N_EN-1:0]   enables;
   logic              vec_sel;
   logic              cmd_valid;
   logic              load_done;
   logic              rx_error;

   modport master (
      output rx_data, rx_ready, op_done,
      input  wr_en_a, wr_en_b, wr_addr, wr_data, enables, vec_sel,
             cmd_valid, load_done, rx_error
   );

   modport slave (
      input  rx_data, rx_ready, op_done,
      output wr_en_a, wr_en_b, wr_addr, wr_data, enables, vec_sel,
             cmd_valid, load_done, rx_error
   );

endinterface

// File: rtl/rx_timeout_timer.sv
// Counts idle cycles while enabled; expire is high during the RX_TIMEOUT-th
// consecutive idle cycle. RX_TIMEOUT=0 disables expiry entirely.
module rx_timeout_timer #(
   parameter int unsigned RX_TIMEOUT = 2000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CNT_W = (RX_TIMEOUT > 1) ? $clog2(RX_TIMEOUT) : 1;
   localparam int unsigned LIMIT = (RX_TIMEOUT > 0) ? RX_TIMEOUT - 1 : 0;

   logic [CNT_W-1:0] cnt_q;

   // A clear in the expiry cycle wins, so a byte arriving right at the limit is kept.
   assign expire = (RX_TIMEOUT != 0) && enable && !clear && (cnt_q == CNT_W'(LIMIT));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 cnt_q <= '0;
      else if (clear || !enable)  cnt_q <= '0;
      else if (!expire)           cnt_q <= cnt_q + CNT_W'(1);
   end

endmodule

// File: rtl/input_cmd_decoder.sv
// Decodes one-byte opcodes from the UART RX stream, streams vector payloads into
// the A/B BRAMs and issues one-hot operation enables, then waits for op_done.
module input_cmd_decoder
   import ipd_pkg::*;
   #(
   parameter int unsigned N_ELEMENTS = 1024,
   parameter int unsigned RX_TIMEOUT = 2000000
) (
   input logic                 clk,
   input logic                 reset,
   input_cmd_decoder_if.slave  bus
);

   localparam int unsigned ADDR_W = (N_ELEMENTS > 1) ? $clog2(N_ELEMENTS) : 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_ELEMENTS - 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] count_q, count_d;
   logic              last_q, last_d;     // final element written, load_done due next
   logic              tgt_b_q, tgt_b_d;
   logic              wr_en_a_q, wr_en_a_d, wr_en_b_q, wr_en_b_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [ELEM_W-1:0] wr_data_q, wr_data_d;
   logic [N_EN-1:0]   enables_q, enables_d;
   logic              vec_sel_q, vec_sel_d;
   logic              cmd_valid_q, cmd_valid_d;
   logic              load_done_q, load_done_d;
   logic              rx_error_q, rx_error_d;
   logic              expire;

   rx_timeout_timer #(.RX_TIMEOUT(RX_TIMEOUT)) u_timer (
      .clk    (clk),
      .rst_n  (reset),
      .clear  (bus.rx_ready),
      .enable (state_q == ST_LOAD && !last_q),
      .expire (expire)
   );

   // NOTE: every signal gets a default before the case so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      last_d      = last_q;
      tgt_b_d     = tgt_b_q;
      wr_en_a_d   = 1'b0;
      wr_en_b_d   = 1'b0;
      wr_addr_d   = wr_addr_q;
      wr_data_d   = wr_data_q;
      enables_d   = '0;
      vec_sel_d   = 1'b0;
      cmd_valid_d = 1'b0;
      load_done_d = 1'b0;
      rx_error_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: if (bus.rx_ready) begin
            case (bus.rx_data)
               OP_LOAD_A, OP_LOAD_B: begin
                  state_d   = ST_LOAD;
                  count_d   = '0;
                  last_d    = 1'b0;
                  wr_addr_d = '0;
                  tgt_b_d   = (bus.rx_data == OP_LOAD_B);
               end
               OP_READ_A, OP_READ_B, OP_SUM, OP_AVG, OP_EUC, OP_MAN, OP_DOT: begin
                  state_d     = ST_ISSUE;
                  cmd_valid_d = 1'b1;
                  enables_d   = op_enables(bus.rx_data);
                  vec_sel_d   = (bus.rx_data == OP_READ_B);
               end
               default: rx_error_d = 1'b1;
            endcase
         end
         ST_LOAD: begin
            if (last_q) begin
               load_done_d = 1'b1;
               last_d      = 1'b0;
               count_d     = '0;
               state_d     = ST_IDLE;
            end else if (bus.rx_ready) begin
               wr_en_a_d = !tgt_b_q;
               wr_en_b_d = tgt_b_q;
               wr_addr_d = count_q;
               wr_data_d = bus.rx_data;
               if (count_q == LAST_ADDR) begin
                  last_d  = 1'b1;
                  count_d = '0;
               end else begin
                  count_d = count_q + ADDR_W'(1);
               end
            end else if (expire) begin
               rx_error_d = 1'b1;
               count_d    = '0;
               state_d    = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            rx_error_d = bus.rx_ready;
            state_d    = ST_BUSY;
         end
         ST_BUSY: begin
            rx_error_d = bus.rx_ready;
            if (bus.op_done) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         count_q     <= '0;
         last_q      <= 1'b0;
         tgt_b_q     <= 1'b0;
         wr_en_a_q   <= 1'b0;
         wr_en_b_q   <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= '0;
         enables_q   <= '0;
         vec_sel_q   <= 1'b0;
         cmd_valid_q <= 1'b0;
         load_done_q <= 1'b0;
         rx_error_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         last_q      <= last_d;
         tgt_b_q     <= tgt_b_d;
         wr_en_a_q   <= wr_en_a_d;
         wr_en_b_q   <= wr_en_b_d;
         wr_addr_q   <= wr_addr_d;
         wr_data_q   <= wr_data_d;
         enables_q   <= enables_d;
         vec_sel_q   <= vec_sel_d;
         cmd_valid_q <= cmd_valid_d;
         load_done_q <= load_done_d;
         rx_error_q  <= rx_error_d;
      end
   end

   assign bus.wr_en_a   = wr_en_a_q;
   assign bus.wr_en_b   = wr_en_b_q;
   assign bus.wr_addr   = wr_addr_q;
   assign bus.wr_data   = wr_data_q;
   assign bus.enables   = enables_q;
   assign bus.vec_sel   = vec_sel_q;
   assign bus.cmd_valid = cmd_valid_q;
   assign bus.load_done = load_done_q;
   assign bus.rx_error  = rx_error_q;

endmodule

// File: tb/tb_input_cmd_decoder.sv
// Scoreboard bench for input_cmd_decoder: stimulus pushes expected output events
// (kind, cycle, fields); a negedge monitor pops and compares each observed event.
module tb_input_cmd_decoder;
   import ipd_pkg::*;

   localparam int unsigned N  = 4;
   localparam int unsigned TO = 50;

   typedef enum int {K_WA, K_WB, K_CMD, K_DONE, K_ERR} kind_e;
   typedef struct {
      kind_e       kind;
      int          cyc;
      logic [7:0]  addr;
      logic [7:0]  data;
      logic [5:0]  en;
      logic        vs;
   } ev_t;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   int   cyc      = 0;
   int   drv      = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   ev_t  exp_q[$];

   input_cmd_decoder_if #(.N_ELEMENTS(N)) bus();

   input_cmd_decoder #(.N_ELEMENTS(N), .RX_TIMEOUT(TO)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [63:0] pack_ev(input ev_t e);
      return {12'h0, 4'(e.kind), 20'(e.cyc), e.addr, e.data, 2'b00, e.en, 3'b000, e.vs};
   endfunction

   function automatic void push(input kind_e k, input int c, input int a,
                                input logic [7:0] d, input logic [5:0] en, input logic vs);
      ev_t e;
      e.kind = k; e.cyc = c; e.addr = 8'(a); e.data = d; e.en = en; e.vs = vs;
      exp_q.push_back(e);
   endfunction

   task automatic observe(input kind_e k, input string name);
      ev_t got, e;
      got.kind = k;
      got.cyc  = cyc;
      got.addr = (k == K_WA || k == K_WB) ? 8'(bus.wr_addr) : 8'h00;
      got.data = (k == K_WA || k == K_WB) ? bus.wr_data : 8'h00;
      got.en   = (k == K_CMD) ? bus.enables : 6'b0;
      got.vs   = (k == K_CMD) ? bus.vec_sel : 1'b0;
      if (exp_q.size() == 0) begin
         check({"unexpected_", name}, pack_ev(got), 64'h0);
      end else begin
         e = exp_q.pop_front();
         check(name, pack_ev(got), pack_ev(e));
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (bus.wr_en_a)   observe(K_WA,   "wr_a");
         if (bus.wr_en_b)   observe(K_WB,   "wr_b");
         if (bus.cmd_valid) observe(K_CMD,  "cmd");
         if (bus.load_done) observe(K_DONE, "load_done");
         if (bus.rx_error)  observe(K_ERR,  "rx_error");
         if (!bus.cmd_valid) check("idle_enables", 64'(bus.enables), 64'h0);
      end
   end

   task automatic check_all_zero(input string name);
      check(name, 64'({bus.wr_en_a, bus.wr_en_b, bus.wr_addr, bus.wr_data, bus.enables,
                       bus.vec_sel, bus.cmd_valid, bus.load_done, bus.rx_error}), 64'h0);
   endtask

   task automatic put(input logic [7:0] b);
      @(negedge clk);
      bus.rx_data  = b;
      bus.rx_ready = 1'b1;
      drv = cyc;
   endtask

   task automatic gap(input int n);
      repeat (n) begin
         @(negedge clk);
         bus.rx_ready = 1'b0;
      end
   endtask

   task automatic done_pulse();
      @(negedge clk);
      bus.rx_ready = 1'b0;
      bus.op_done  = 1'b1;
      @(negedge clk);
      bus.op_done  = 1'b0;
   endtask

   initial begin
      bus.rx_data  = 8'h00;
      bus.rx_ready = 1'b0;
      bus.op_done  = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset_state");
      reset = 1'b1;
      gap(2);

      // Load A, bytes back-to-back
      put(8'h01);
      put(8'h11); push(K_WA, drv + 1, 0, 8'h11, 6'b0, 1'b0);
      put(8'h22); push(K_WA, drv + 1, 1, 8'h22, 6'b0, 1'b0);
      put(8'h33); push(K_WA, drv + 1, 2, 8'h33, 6'b0, 1'b0);
      put(8'h44); push(K_WA, drv + 1, 3, 8'h44, 6'b0, 1'b0);
      push(K_DONE, drv + 2, 0, 8'h00, 6'b0, 1'b0);
      gap(3);

      // Dot, byte while busy, then sum after op_done
      put(8'h09); push(K_CMD, drv + 1, 0, 8'h00, 6'b100000, 1'b0);
      gap(4);
      put(8'h05); push(K_ERR, drv + 1, 0, 8'h00, 6'b0, 1'b0);
      gap(3);
      done_pulse();
      put(8'h05); push(K_CMD, drv + 1, 0, 8'h00, 6'b000010, 1'b0);
      gap(2);
      done_pulse();

      // Read B, then bad opcode in IDLE
      put(8'h04); push(K_CMD, drv + 1, 0, 8'h00, 6'b000001, 1'b1);
      gap(2);
      done_pulse();
      put(8'h0A); push(K_ERR, drv + 1, 0, 8'h00, 6'b0, 1'b0);
      gap(3);

      // op_done in IDLE is ignored; read A still issues
      done_pulse();
      put(8'h03); push(K_CMD, drv + 1, 0, 8'h00, 6'b000001, 1'b0);
      gap(2);
      done_pulse();

      // Timeout mid-load of B, then a clean load of B from address 0
      put(8'h02);
      put(8'hAA); push(K_WB, drv + 1, 0, 8'hAA, 6'b0, 1'b0);
      push(K_ERR, drv + int'(TO) + 1, 0, 8'h00, 6'b0, 1'b0);
      gap(int'(TO) + 5);
      put(8'h02);
      for (int i = 0; i < int'(N); i++) begin
         put(8'hB0 + 8'(i));
         push(K_WB, drv + 1, i, 8'hB0 + 8'(i), 6'b0, 1'b0);
      end
      push(K_DONE, drv + 2, 0, 8'h00, 6'b0, 1'b0);
      gap(3);

      // Byte lands in the very cycle the timer would expire
      put(8'h01);
      put(8'h5A); push(K_WA, drv + 1, 0, 8'h5A, 6'b0, 1'b0);
      gap(int'(TO) - 1);
      put(8'h6B); push(K_WA, drv + 1, 1, 8'h6B, 6'b0, 1'b0);
      put(8'h7C); push(K_WA, drv + 1, 2, 8'h7C, 6'b0, 1'b0);
      put(8'h8D); push(K_WA, drv + 1, 3, 8'h8D, 6'b0, 1'b0);
      push(K_DONE, drv + 2, 0, 8'h00, 6'b0, 1'b0);
      gap(3);

      // Asynchronous reset while a write strobe is high
      put(8'h01);
      put(8'h55); push(K_WA, drv + 1, 0, 8'h55, 6'b0, 1'b0);
      put(8'h66);
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      check_all_zero("async_reset");
      bus.rx_ready = 1'b0;
      @(negedge clk);
      check_all_zero("reset_held");
      reset = 1'b1;
      gap(1);
      put(8'h07); push(K_CMD, drv + 1, 0, 8'h00, 6'b001000, 1'b0);
      gap(2);
      done_pulse();
      gap(3);

      check("queue_empty", 64'(exp_q.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
